mem_bus_arbiter: RTL



---
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-master arbiter between the CPU core and a second master (DMA/video/loader)
// sharing one single-port memory (8-bit data, 20-bit address, registered read).
// Every access is a fixed three-cycle sequence: S_IDLE (arbitrate), S_ADDR
// (address/data/write strobe on the bus), S_DATA (ack and read data to owner).
// The CPU has priority. Defining ARB_STARVE_EN adds starvation protection that
// forces the DMA master onto the bus for a burst of BURST transactions after
// it has waited STARVE cycles.
//
// Ports:
//   clock, reset                         system clock, synchronous active-high reset
//   cpu_req/address/out/wren  (in)       CPU bus-cycle request and fields
//   cpu_ack, cpu_data         (out)      CPU completion pulse and read data
//   dma_req/address/out/wren  (in)       DMA bus-cycle request and fields
//   dma_ack, dma_data         (out)      DMA completion pulse and read data
//   address, out, wren        (out)      memory address, write data, write strobe
//   data                      (in)       memory read data (one cycle after address)
//   owner                     (out)      0 = CPU, 1 = DMA; current/last master
//
// Macro: ARB_STARVE_EN enables the starvation counter and burst grant.

module mem_bus_arbiter #(
    parameter int BURST  = 4,
    parameter int STARVE = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_wren,
    output logic        cpu_ack,
    output logic [7:0]  cpu_data,
    input  logic        dma_req,
    input  logic [19:0] dma_address,
    input  logic [7:0]  dma_out,
    input  logic        dma_wren,
    output logic        dma_ack,
    output logic [7:0]  dma_data,
    output logic [19:0] address,
    output logic [7:0]  out,
    output logic        wren,
    input  logic [7:0]  data,
    output logic        owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic [19:0] r_address;
    logic [7:0]  r_out;
    logic        r_wren;
    logic        w_grant;
    logic        w_grant_dma;
    logic        w_force_dma;
    logic        w_in_data;

    if (BURST < 1 || STARVE < 1) begin : g_cfg_check
        $error("mem_bus_arbiter: BURST and STARVE must both be at least 1");
    end

`ifdef ARB_STARVE_EN
    localparam int SW = $clog2(STARVE + 1);
    localparam int BW = $clog2(BURST + 1);

    logic [SW-1:0] r_starv;
    logic [BW-1:0] r_burst;
    logic          w_starved;

    assign w_starved = (r_starv == SW'(STARVE));

    // An outstanding burst or a saturated wait counter overrides CPU priority.
    assign w_force_dma = dma_req && ((r_burst != '0) || w_starved);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starv <= '0;
            r_burst <= '0;
        end else begin
            if (w_grant && w_grant_dma) begin
                r_starv <= '0;
            end else if (dma_req && !(r_owner && r_state != S_IDLE) && !w_starved) begin
                r_starv <= r_starv + SW'(1);
            end

            if (r_state == S_IDLE) begin
                if (!dma_req) begin
                    r_burst <= '0;
                end else if (r_burst != '0) begin
                    r_burst <= r_burst - BW'(1);
                end else if (w_starved) begin
                    // The transaction granted now is the first of the burst.
                    r_burst <= BW'(BURST - 1);
                end
            end
        end
    end
`else
    assign w_force_dma = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_dma = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    w_grant     = 1'b1;
                    w_grant_dma = dma_req && (!cpu_req || w_force_dma);
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR:  w_state_nxt = S_DATA;
            S_DATA:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_address <= '0;
            r_out     <= '0;
            r_wren    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Strobe is high only in the S_ADDR cycle that follows a grant.
            r_wren  <= 1'b0;
            if (w_grant) begin
                r_owner   <= w_grant_dma;
                r_address <= w_grant_dma ? dma_address : cpu_address;
                r_out     <= w_grant_dma ? dma_out     : cpu_out;
                r_wren    <= w_grant_dma ? dma_wren    : cpu_wren;
            end
        end
    end

    assign w_in_data = (r_state == S_DATA);

    assign address  = r_address;
    assign out      = r_out;
    assign wren     = r_wren;
    assign owner    = r_owner;
    assign cpu_ack  = w_in_data && !r_owner;
    assign dma_ack  = w_in_data && r_owner;
    assign cpu_data = cpu_ack ? data : 8'h00;
    assign dma_data = dma_ack ? data : 8'h00;

endmodule
